// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-control bundle between the sequencer (master) and the datapath (slave).
// The stall_cycles member exists only when STALL_CNT_EN is defined.
interface pipeline_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       mem_memread;
  logic       mem_memwrite;
  logic       dmem_ready;
  logic       dmem_req;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       memwb_bubble;
  logic       mem_timeout;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  modport master (
    input  id_rs, id_rt, ex_memread, ex_rt, ex_branch_taken,
    input  mem_memread, mem_memwrite, dmem_ready,
    output dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_bubble, memwb_bubble, mem_timeout
`ifdef STALL_CNT_EN
    , output stall_cycles
`endif
  );

  modport slave (
    output id_rs, id_rt, ex_memread, ex_rt, ex_branch_taken,
    output mem_memread, mem_memwrite, dmem_ready,
    input  dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_bubble, memwb_bubble, mem_timeout
`ifdef STALL_CNT_EN
    , input stall_cycles
`endif
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       luse
);

  // Writes to the zero register never create a real dependency.
  assign luse = ex_memread && (ex_rt != ZERO_REG) &&
                ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: memory freeze, load-use bubble and taken-branch flush control.
// Optional STALL_CNT_EN adds a saturating stall_cycles counter on the interface.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.master bus
);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [16:0] cnt_inc;
  logic        timeout_hit;
  logic        mem_access;
  logic        luse;
  logic        dmem_req_q;
  logic        timeout_q;
  logic        freeze;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_bubble, memwb_bubble;

  assign mem_access  = bus.mem_memread | bus.mem_memwrite;
  assign cnt_inc     = {1'b0, wait_cnt} + 17'd1;
  assign timeout_hit = (cnt_inc == 17'(TIMEOUT_CYC));
  assign freeze      = (state == MEM_WAIT) || ((state == RUN) && mem_access);

  hazard_detect u_hazard (
    .ex_memread (bus.ex_memread),
    .ex_rt      (bus.ex_rt),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .luse       (luse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      wait_cnt   <= '0;
      dmem_req_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_access) begin
            state      <= MEM_WAIT;
            dmem_req_q <= 1'b1;
          end
        end
        MEM_WAIT: begin
          wait_cnt <= cnt_inc[15:0];
          if (bus.dmem_ready) begin
            state      <= MEM_DONE;
            dmem_req_q <= 1'b0;
          end else if (timeout_hit) begin
            state      <= MEM_DONE;
            dmem_req_q <= 1'b0;
            timeout_q  <= 1'b1;
          end
        end
        MEM_DONE: begin
          state      <= RUN;
          wait_cnt   <= '0;
          dmem_req_q <= 1'b0;
        end
        default: begin
          state      <= RUN;
          wait_cnt   <= '0;
          dmem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Reset forces a safe all-hold/all-bubble pattern; branch flush outranks load-use.
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b1;
    memwb_bubble = 1'b1;
    if (!rst) begin
      if (freeze) begin
        memwb_en     = 1'b1;
        idex_bubble  = 1'b0;
      end else begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        if (bus.ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (luse) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
    end
  end

  assign bus.dmem_req     = dmem_req_q;
  assign bus.mem_timeout  = timeout_q;
  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.idex_en      = idex_en;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_en     = memwb_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.memwb_bubble = memwb_bubble;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (default and TIMEOUT_CYC=3 instances).
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if bus_a ();
  pipeline_ctrl_if bus_b ();

  pipeline_ctrl dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipeline_ctrl #(.TIMEOUT_CYC(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, memwb_bubble}
  localparam logic [7:0] RESET_V = 8'b0000_0011;
  localparam logic [7:0] ALL_EN  = 8'b1111_1000;
  localparam logic [7:0] FREEZE  = 8'b0000_1001;
  localparam logic [7:0] LUSE    = 8'b0011_1010;
  localparam logic [7:0] BRANCH  = 8'b1111_1110;

  logic [7:0] ctrl_a;
  logic [7:0] ctrl_b;
  assign ctrl_a = {bus_a.pc_en, bus_a.ifid_en, bus_a.idex_en, bus_a.exmem_en,
                   bus_a.memwb_en, bus_a.ifid_flush, bus_a.idex_bubble, bus_a.memwb_bubble};
  assign ctrl_b = {bus_b.pc_en, bus_b.ifid_en, bus_b.idex_en, bus_b.exmem_en,
                   bus_b.memwb_en, bus_b.ifid_flush, bus_b.idex_bubble, bus_b.memwb_bubble};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic mrd, input logic mwr, input logic rdy,
                               input logic exrd, input logic [4:0] exrt,
                               input logic [4:0] rs, input logic [4:0] rt, input logic br);
    bus_a.mem_memread     = mrd;
    bus_a.mem_memwrite    = mwr;
    bus_a.dmem_ready      = rdy;
    bus_a.ex_memread      = exrd;
    bus_a.ex_rt           = exrt;
    bus_a.id_rs           = rs;
    bus_a.id_rt           = rt;
    bus_a.ex_branch_taken = br;
    #1;
  endtask

  task automatic applyStimulusB(input logic mwr, input logic rdy);
    bus_b.mem_memwrite = mwr;
    bus_b.dmem_ready   = rdy;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus_b.id_rs = '0; bus_b.id_rt = '0; bus_b.ex_memread = 1'b0; bus_b.ex_rt = '0;
    bus_b.ex_branch_taken = 1'b0; bus_b.mem_memread = 1'b0;
    #1;
    applyStimulusB(0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_ctrl", 32'(ctrl_a), 32'(RESET_V));
    checkOutput("reset_req", 32'(bus_a.dmem_req), 0);
    checkOutput("reset_timeout", 32'(bus_a.mem_timeout), 0);
    checkOutput("reset_ctrl_b", 32'(ctrl_b), 32'(RESET_V));
    rst = 1'b0;

    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("run_idle", 32'(ctrl_a), 32'(ALL_EN));

    // Load with ready on the fourth wait cycle
    tick(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mem_detect", 32'(ctrl_a), 32'(FREEZE));
    checkOutput("mem_detect_req", 32'(bus_a.dmem_req), 0);
    for (int i = 1; i <= 4; i++) begin
      tick(); applyStimulus(1, 0, logic'(i == 4), 0, 0, 0, 0, 0);
      checkOutput("mem_wait", 32'(ctrl_a), 32'(FREEZE));
      checkOutput("mem_wait_req", 32'(bus_a.dmem_req), 1);
    end
    tick(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mem_done", 32'(ctrl_a), 32'(ALL_EN));
    checkOutput("mem_done_req", 32'(bus_a.dmem_req), 0);
`ifdef STALL_CNT_EN
    checkOutput("stall_after_mem", bus_a.stall_cycles, 5);
`endif
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mem_after", 32'(ctrl_a), 32'(ALL_EN));

    tick(); applyStimulus(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    checkOutput("luse_rs", 32'(ctrl_a), 32'(LUSE));
    tick(); applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    checkOutput("luse_zero_reg", 32'(ctrl_a), 32'(ALL_EN));
    tick(); applyStimulus(0, 0, 0, 1, 5'd8, 5'd3, 5'd8, 0);
    checkOutput("luse_rt", 32'(ctrl_a), 32'(LUSE));
    tick(); applyStimulus(0, 0, 0, 0, 5'd8, 5'd8, 5'd8, 0);
    checkOutput("no_memread", 32'(ctrl_a), 32'(ALL_EN));
    tick(); applyStimulus(0, 0, 0, 1, 5'd9, 5'd0, 5'd9, 1);
    checkOutput("branch_over_luse", 32'(ctrl_a), 32'(BRANCH));
    tick(); applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    checkOutput("branch_only", 32'(ctrl_a), 32'(BRANCH));
`ifdef STALL_CNT_EN
    checkOutput("stall_mid", bus_a.stall_cycles, 7);
`endif

    // Memory stall outranks a branch, then reset lands in the third wait cycle
    tick(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("mem_over_branch", 32'(ctrl_a), 32'(FREEZE));
    for (int i = 1; i <= 3; i++) begin
      tick(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("abort_wait_req", 32'(bus_a.dmem_req), 1);
    end
    rst = 1'b1;
    #1;
    checkOutput("rst_async_req", 32'(bus_a.dmem_req), 0);
    checkOutput("rst_async_ctrl", 32'(ctrl_a), 32'(RESET_V));
    checkOutput("rst_async_timeout", 32'(bus_a.mem_timeout), 0);
`ifdef STALL_CNT_EN
    checkOutput("rst_stall", bus_a.stall_cycles, 0);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_run", 32'(ctrl_a), 32'(ALL_EN));
    checkOutput("post_rst_req", 32'(bus_a.dmem_req), 0);

    // Back-to-back loads, ready held high (ignored outside MEM_WAIT)
    tick(); applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("b2b_run1", 32'(ctrl_a), 32'(FREEZE));
    checkOutput("b2b_run1_req", 32'(bus_a.dmem_req), 0);
    tick(); applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("b2b_wait1", 32'(ctrl_a), 32'(FREEZE));
    checkOutput("b2b_wait1_req", 32'(bus_a.dmem_req), 1);
    tick(); applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("b2b_done1", 32'(ctrl_a), 32'(ALL_EN));
    checkOutput("b2b_done1_req", 32'(bus_a.dmem_req), 0);
    tick(); applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("b2b_run2", 32'(ctrl_a), 32'(FREEZE));
    tick(); applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("b2b_wait2", 32'(ctrl_a), 32'(FREEZE));
    checkOutput("b2b_wait2_req", 32'(bus_a.dmem_req), 1);
    tick(); applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("b2b_done2", 32'(ctrl_a), 32'(ALL_EN));
`ifdef STALL_CNT_EN
    checkOutput("b2b_stall", bus_a.stall_cycles, 4);
`endif
    tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("b2b_after", 32'(ctrl_a), 32'(ALL_EN));

    // Timeout instance: store with ready never asserted
    tick(); applyStimulusB(1, 0);
    checkOutput("to_detect", 32'(ctrl_b), 32'(FREEZE));
    for (int i = 1; i <= 3; i++) begin
      tick(); applyStimulusB(1, 0);
      checkOutput("to_wait", 32'(ctrl_b), 32'(FREEZE));
      checkOutput("to_wait_req", 32'(bus_b.dmem_req), 1);
      checkOutput("to_wait_flag", 32'(bus_b.mem_timeout), 0);
    end
    tick(); applyStimulusB(1, 0);
    checkOutput("to_done", 32'(ctrl_b), 32'(ALL_EN));
    checkOutput("to_done_req", 32'(bus_b.dmem_req), 0);
    checkOutput("to_done_flag", 32'(bus_b.mem_timeout), 1);
    tick(); applyStimulusB(0, 0);
    checkOutput("to_run", 32'(ctrl_b), 32'(ALL_EN));
    repeat (3) tick();
    checkOutput("to_sticky", 32'(bus_b.mem_timeout), 1);
    rst = 1'b1;
    #1;
    checkOutput("to_rst_clear", 32'(bus_b.mem_timeout), 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
